// File: rtl/sif_xa_arbiter.sv
// sif_xa_arbiter
//   Shares the single SIF external-agent (xa) register port among NUM_REQ
//   requesters. Each accepted request is one read or one write transaction.
//   The arbiter issues the xa strobe for one cycle. For a read, it returns
//   xa_data_rd to the owner RD_LAT cycles after the strobe.
//
//   Configuration macro: SIF_XA_ARB_RR_EN
//     defined   - round-robin selection; the search starts after last_grant
//     undefined - fixed priority; the lowest-index valid requester wins
//
// Ports
//   clk, rst      clock and synchronous active-high reset
//   req_valid     per-requester request valid
//   req_ready     one-hot accept, asserted combinationally in IDLE
//   req_wr        per-requester direction (1 = write, 0 = read)
//   req_addr      packed addresses, requester i at [i*AW +: AW]
//   req_wdata     packed write data, same packing
//   rsp_valid     one-cycle read-data pulse to the read's owner
//   rsp_rdata     read data, valid while any rsp_valid bit is high
//   busy          high whenever the FSM is not IDLE
//   xa_wr_s       write strobe, one cycle per write
//   xa_rd_s       read strobe, one cycle per read
//   xa_addr       transaction address, held between transactions
//   xa_data_wr    write data, held between transactions
//   xa_data_rd    read data from the xa slave
module sif_xa_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_wr,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  busy,
    output logic                  xa_wr_s,
    output logic                  xa_rd_s,
    output logic [AW-1:0]         xa_addr,
    output logic [DW-1:0]         xa_data_wr,
    input  logic [DW-1:0]         xa_data_rd
);

    localparam int unsigned GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            wr_q;
    logic [GW-1:0]   owner;
    logic [2:0]      cnt;
    logic            sel_found;
    logic [GW-1:0]   sel_idx;
    logic [GW-1:0]   cand;
`ifdef SIF_XA_ARB_RR_EN
    logic [GW-1:0]   last_grant;
`endif

    // Winner selection. The first valid candidate in search order wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef SIF_XA_ARB_RR_EN
            cand = GW'((32'(last_grant) + 32'd1 + i) % NUM_REQ);
`else
            cand = GW'(i);
`endif
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        xa_wr_s    = 1'b0;
        xa_rd_s    = 1'b0;
        busy       = (state != IDLE);
        unique case (state)
            IDLE: begin
                // Gate with rst so that no accept is signalled during reset.
                if (sel_found && !rst) begin
                    req_ready[sel_idx] = 1'b1;
                    state_next         = ISSUE;
                end
            end
            ISSUE: begin
                xa_wr_s    = wr_q;
                xa_rd_s    = !wr_q;
                state_next = wr_q ? IDLE : WAIT_RD;
            end
            WAIT_RD: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= 1'b0;
            owner      <= '0;
            cnt        <= '0;
            xa_addr    <= '0;
            xa_data_wr <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
`ifdef SIF_XA_ARB_RR_EN
            last_grant <= GW'(NUM_REQ - 1);
`endif
        end else begin
            rsp_valid <= '0;
            unique case (state)
                IDLE: begin
                    if (sel_found) begin
                        // Address and data registers double as the xa outputs,
                        // so they hold their values until the next accept.
                        wr_q       <= req_wr[sel_idx];
                        owner      <= sel_idx;
                        xa_addr    <= req_addr[32'(sel_idx) * AW +: AW];
                        xa_data_wr <= req_wdata[32'(sel_idx) * DW +: DW];
`ifdef SIF_XA_ARB_RR_EN
                        last_grant <= sel_idx;
`endif
                    end
                end
                ISSUE: begin
                    cnt <= 3'(RD_LAT - 1);
                end
                WAIT_RD: begin
                    if (cnt == '0) begin
                        rsp_rdata        <= xa_data_rd;
                        rsp_valid[owner] <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sif_xa_arbiter.sv
module tb_sif_xa_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned AW      = 16;
    localparam int unsigned DW      = 16;
    localparam int unsigned RD_LAT  = 3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_wr = '0;
    logic [NUM_REQ*AW-1:0] req_addr = '0;
    logic [NUM_REQ*DW-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [DW-1:0]         rsp_rdata;
    logic                  busy;
    logic                  xa_wr_s;
    logic                  xa_rd_s;
    logic [AW-1:0]         xa_addr;
    logic [DW-1:0]         xa_data_wr;
    logic [DW-1:0]         xa_data_rd = '0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [0:255];

    always #5 clk = ~clk;

    sif_xa_arbiter #(
        .NUM_REQ(NUM_REQ),
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .xa_wr_s   (xa_wr_s),
        .xa_rd_s   (xa_rd_s),
        .xa_addr   (xa_addr),
        .xa_data_wr(xa_data_wr),
        .xa_data_rd(xa_data_rd)
    );

    // Simple xa slave: writes land in mem, reads are captured on the strobe.
    always @(posedge clk) begin
        if (xa_wr_s) mem[xa_addr[7:0]] <= xa_data_wr;
        if (xa_rd_s) xa_data_rd <= mem[xa_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_wr[i]              = wr;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
    endtask

    task automatic idle_quiet(input string tag);
        check({tag, "_wr_s"}, 32'(xa_wr_s), 32'd0);
        check({tag, "_rd_s"}, 32'(xa_rd_s), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [NUM_REQ-1:0] exp_grant;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h20] = 16'h1234;

        // Reset with all requesters asserting valid
        rst       = 1'b1;
        req_valid = 4'hF;
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            check("rst_ready", 32'(req_ready), 32'd0);
            idle_quiet("rst");
            check("rst_addr", 32'(xa_addr), 32'd0);
            check("rst_wdata", 32'(xa_data_wr), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        tick();
        rst       = 1'b0;
        req_valid = '0;

        // Single write from requester 2
        tick();
        set_req(2, 1'b1, 16'h0010, 16'hBEEF);
        req_valid = 4'b0100;
        #1;
        check("wr_ready", 32'(req_ready), 32'b0100);
        check("wr_busy_idle", 32'(busy), 32'd0);
        tick();
        req_valid = '0;
        #1;
        check("wr_strobe", 32'(xa_wr_s), 32'd1);
        check("wr_no_rd", 32'(xa_rd_s), 32'd0);
        check("wr_addr", 32'(xa_addr), 32'h0010);
        check("wr_data", 32'(xa_data_wr), 32'hBEEF);
        check("wr_busy", 32'(busy), 32'd1);
        check("wr_ready_issue", 32'(req_ready), 32'd0);
        tick();
        #1;
        idle_quiet("wr_after");
        check("wr_busy_after", 32'(busy), 32'd0);
        check("wr_addr_hold", 32'(xa_addr), 32'h0010);

        // Read from requester 1, RD_LAT = 3: response in cycle T+5
        tick();
        set_req(1, 1'b0, 16'h0020, 16'h0000);
        req_valid = 4'b0010;
        #1;
        check("rd_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        #1;
        check("rd_strobe", 32'(xa_rd_s), 32'd1);
        check("rd_no_wr", 32'(xa_wr_s), 32'd0);
        check("rd_addr", 32'(xa_addr), 32'h0020);
        for (int c = 2; c <= 4; c++) begin
            tick();
            #1;
            idle_quiet("rd_wait");
            check("rd_wait_busy", 32'(busy), 32'd1);
        end
        tick();
        #1;
        check("rd_rsp_valid", 32'(rsp_valid), 32'b0010);
        check("rd_rsp_data", 32'(rsp_rdata), 32'h1234);
        check("rd_busy_done", 32'(busy), 32'd0);
        tick();
        #1;
        check("rd_rsp_pulse", 32'(rsp_valid), 32'd0);

        // Fairness: restart from reset, all four writing continuously
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 16'(16'h0100 + i), 16'(16'hC000 + i));
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
`ifdef SIF_XA_ARB_RR_EN
            exp_grant = 4'(1 << (k % 4));
`else
            exp_grant = 4'b0001;
`endif
            #1;
            check("rr_grant", 32'(req_ready), 32'(exp_grant));
            tick();
            #1;
            check("rr_strobe", 32'(xa_wr_s), 32'd1);
`ifdef SIF_XA_ARB_RR_EN
            check("rr_addr", 32'(xa_addr), 32'(16'h0100 + (k % 4)));
`else
            check("rr_addr", 32'(xa_addr), 32'h0100);
`endif
            check("rr_ready_issue", 32'(req_ready), 32'd0);
            tick();
        end
        req_valid = '0;

        // Reset during WAIT_RD, then requester 0 must be first
        set_req(2, 1'b0, 16'h0030, 16'h0000);
        req_valid = 4'b0100;
        #1;
        check("mr_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        #1;
        check("mr_rd_strobe", 32'(xa_rd_s), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check("mr_busy_wait", 32'(busy), 32'd1);
        check("mr_ready_rst", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 16'h0040, 16'h5555);
        set_req(3, 1'b1, 16'h0050, 16'h6666);
        req_valid = 4'b1001;
        #1;
        check("mr_busy_after", 32'(busy), 32'd0);
        idle_quiet("mr_after");
        check("mr_first_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b1000;
        #1;
        check("mr_wr0_addr", 32'(xa_addr), 32'h0040);
        check("mr_no_rsp1", 32'(rsp_valid), 32'd0);
        tick();
        #1;
        check("mr_second_grant", 32'(req_ready), 32'b1000);
        check("mr_no_rsp2", 32'(rsp_valid), 32'd0);
        tick();
        req_valid = '0;
        #1;
        check("mr_wr3_addr", 32'(xa_addr), 32'h0050);
        check("mr_no_rsp3", 32'(rsp_valid), 32'd0);
        tick();
        #1;
        idle_quiet("mr_end");

        // Mixed: req 0 writes 0x0005 <- 0xAAAA while req 3 reads 0x0005
        tick();
        set_req(0, 1'b1, 16'h0005, 16'hAAAA);
        set_req(3, 1'b0, 16'h0005, 16'h0000);
        req_valid = 4'b1001;
        #1;
        check("mx_first", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b1000;
        #1;
        check("mx_wr_s", 32'(xa_wr_s), 32'd1);
        check("mx_wr_no_rd", 32'(xa_rd_s), 32'd0);
        check("mx_wr_addr", 32'(xa_addr), 32'h0005);
        check("mx_wr_data", 32'(xa_data_wr), 32'hAAAA);
        tick();
        #1;
        check("mx_second", 32'(req_ready), 32'b1000);
        check("mx_gap_wr", 32'(xa_wr_s), 32'd0);
        check("mx_gap_rd", 32'(xa_rd_s), 32'd0);
        tick();
        req_valid = '0;
        #1;
        check("mx_rd_s", 32'(xa_rd_s), 32'd1);
        check("mx_rd_no_wr", 32'(xa_wr_s), 32'd0);
        check("mx_rd_addr", 32'(xa_addr), 32'h0005);
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            idle_quiet("mx_wait");
        end
        tick();
        #1;
        check("mx_rsp_valid", 32'(rsp_valid), 32'b1000);
        check("mx_rsp_data", 32'(rsp_rdata), 32'hAAAA);
        tick();
        #1;
        check("mx_rsp_pulse", 32'(rsp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
